dram_bus_frontend: RTL and testbench
====================================

// Module: dram_bus_frontend
// PURPOSE
//  68040 bus-side front end for the DRAM controller: samples nTS and transfer attributes, decodes DRAM hits,
//  expands line (SIZ=11) transfers into 4 wrapped longword beats, and issues one request per beat to the
//  DRAM sequencer over a MEM_REQ/MEM_ACK handshake. Drives nTA per completed beat; nTBI when bursts are
//  disabled; nTEA on sequencer timeout. Sits directly upstream of the RAS/CAS sequencer. Never drives D.
// PARAMETERS
//  DRAM_BASE      24'h000000  base of DRAM window, compared under DRAM_MASK
//  DRAM_MASK      24'hC00000  address bits that must equal DRAM_BASE for a hit
//  TIMEOUT_CYCLES 64          cycles of unacknowledged MEM_REQ before nTEA (>=2)
//  BURST_EN       1           0: line requests complete one beat with nTBI asserted
// PORTS
//  CLK            in   1   system clock; all logic on rising edge
//  RESET          in   1   synchronous, active-high reset
//  A              in   24  68040 address bus
//  TT             in   2   transfer type; 00 normal, 01 MOVE16 hit; 10/11 ignored
//  TM             in   3   transfer modifier; registered, passed out as MEM_TM
//  SIZ            in   2   00 long, 01 byte, 10 word, 11 line
//  RW             in   1   1 read, 0 write
//  nTS            in   1   transfer start, low for one cycle
//  nMI            in   1   memory inhibit; low when nTS sampled -> cycle not claimed
//  nTA            out  1   transfer acknowledge, low one cycle per beat
//  nTBI           out  1   burst inhibit, low together with nTA
//  nTEA           out  1   transfer error acknowledge, low one cycle on timeout
//  MEM_REQ        out  1   beat request to DRAM sequencer
//  MEM_ADDR       out  22  longword address A[23:2] of current beat
//  MEM_BE         out  4   byte enables; BE[3]=D[31:24]
//  MEM_RW         out  1   registered RW
//  MEM_TM         out  3   registered TM
//  MEM_LAST       out  1   high when current beat is the final beat
//  MEM_ACK        in   1   sequencer: beat finished this cycle
// BEHAVIOUR
//  Reset: nTA=nTBI=nTEA=1, MEM_REQ=0, MEM_ADDR=0, MEM_BE=0, MEM_RW=1, MEM_TM=0, MEM_LAST=0, state IDLE.
//   RESET asserted mid-transfer aborts it; no nTA/nTEA is issued.
//  Claim in IDLE: nTS=0 & nMI=1 & TT[1]=0 & (A&DRAM_MASK)==(DRAM_BASE&DRAM_MASK). Otherwise stay IDLE.
//  Claim latches A/RW/TM/SIZ; MEM_REQ rises after the next edge (1-cycle latency from nTS).
//  BE: long/line 1111; byte one-hot by A[1:0] (00->1000 .. 11->0001); word A[1]=0 ->1100, else 0011.
//  Beats: line = 4 (BURST_EN=1) else 1; others 1. Beat k addr = {A[23:4], (A[3:2]+k) mod 4} (wraps 11->00).
//  FSM IDLE -> REQ -> (REQ | IDLE):
//   REQ: MEM_REQ=1 with stable ADDR/BE/RW/LAST until MEM_ACK=1 sampled.
//   On MEM_ACK: nTA=0 next cycle. Last beat -> IDLE, MEM_REQ=0. Else next beat's MEM_REQ/ADDR same cycle as nTA.
//   nTBI=0 with nTA only for a line request when BURST_EN=0.
//  Timeout: counter cleared at each beat issue and increments while MEM_REQ=1 & MEM_ACK=0.
//   At TIMEOUT_CYCLES: MEM_REQ=0, nTEA=0 for one cycle, -> IDLE.
//   MEM_ACK in the same cycle as the limit: ACK wins, no nTEA.
//  nTS while in REQ: ignored.
//   nTS in the cycle nTA/nTEA is driven (state already IDLE): accepted normally.
//  MEM_ACK while MEM_REQ=0: ignored.
// STRUCTURE
//  Package dram_pkg: SIZ_* and TT_* encodings, fsm state enum, BE decode function.
//  Sub-module dram_bus_watchdog (clear/run/expired counter, TIMEOUT_CYCLES param).
//  Top holds FSM, beat counter and address wrap.
// TESTING
//  Long read @24'h000104, ACK 3 cycles after REQ -> one REQ, ADDR=22'h000041, BE=1111, LAST=1, single nTA.
//  Byte write @A[1:0]=10, SIZ=01 -> BE=0010, MEM_RW=0, one nTA.
//  Line read @24'h00001C (BURST_EN=1) -> ADDRs 7,4,5,6 (wrap); LAST only on 4th; four nTA; nTBI high.
//  Same line with BURST_EN=0 -> one beat ADDR=7, nTA and nTBI low together.
//  Out-of-window access @24'hC00000, or nMI=0 at nTS -> no MEM_REQ, no nTA.
//  No ACK for TIMEOUT_CYCLES=8 -> nTEA once, MEM_REQ drops; ACK on limit cycle -> nTA, no nTEA.
//  RESET during beat 2 of a line -> all outputs at reset values next edge.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared encodings, FSM state type and byte-enable decode for the 68040 DRAM bus front end.
package dram_pkg;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam logic [1:0] TT_NORMAL = 2'b00;
    localparam logic [1:0] TT_MOVE16 = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fsmState_t;

    // BE[3] maps to D[31:24], so the lowest byte address selects the top lane.
    function automatic logic [3:0] beDecode(input logic [1:0] siz, input logic [1:0] addrLow);
        case (siz)
            SIZ_BYTE: beDecode = 4'b1000 >> addrLow;
            SIZ_WORD: beDecode = addrLow[1] ? 4'b0011 : 4'b1100;
            default:  beDecode = 4'b1111;
        endcase
    endfunction

    function automatic logic isDramType(input logic [1:0] tt);
        return (tt == TT_NORMAL) || (tt == TT_MOVE16);
    endfunction

endpackage

// File: rtl/dram_bus_watchdog.sv
// Counts cycles of an unanswered request; expired flags the last permitted waiting cycle.
module dram_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == LIMIT);

endmodule

// File: rtl/dram_bus_frontend.sv
// 68040 bus front end: claims DRAM cycles, splits line transfers into wrapped beats and
// hands each beat to the RAS/CAS sequencer over MEM_REQ/MEM_ACK.
module dram_bus_frontend
    import dram_pkg::*;
#(
    parameter logic [23:0] DRAM_BASE      = 24'h000000,
    parameter logic [23:0] DRAM_MASK      = 24'hC00000,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter bit          BURST_EN       = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:0] A,
    input  logic [1:0]  TT,
    input  logic [2:0]  TM,
    input  logic [1:0]  SIZ,
    input  logic        RW,
    input  logic        nTS,
    input  logic        nMI,
    output logic        nTA,
    output logic        nTBI,
    output logic        nTEA,
    output logic        MEM_REQ,
    output logic [21:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic        MEM_RW,
    output logic [2:0]  MEM_TM,
    output logic        MEM_LAST,
    input  logic        MEM_ACK
);

    fsmState_t   state, stateNext;
    logic        claim, beatAck, timeout, lineReq;
    logic        wdClear, wdRun, wdExpired;
    logic [1:0]  beatsLeft, beatsLeftD;
    logic        inhibit, inhibitD;
    logic        reqD, rwD, lastD, nTaD, nTbiD, nTeaD;
    logic [21:0] addrD;
    logic [3:0]  beD;
    logic [2:0]  tmD;

    assign lineReq = (SIZ == SIZ_LINE);
    assign claim   = (state == ST_IDLE) && !nTS && nMI && isDramType(TT)
                     && ((A & DRAM_MASK) == (DRAM_BASE & DRAM_MASK));
    assign beatAck = (state == ST_REQ) && MEM_REQ && MEM_ACK;
    assign timeout = (state == ST_REQ) && !MEM_ACK && wdExpired;
    assign wdClear = (state == ST_IDLE) || beatAck;
    assign wdRun   = MEM_REQ && !MEM_ACK;

    dram_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) watchdog (
        .clk    (CLK),
        .rst    (RESET),
        .clear  (wdClear),
        .run    (wdRun),
        .expired(wdExpired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (claim) stateNext = ST_REQ;
            ST_REQ:  if ((beatAck && MEM_LAST) || timeout) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        reqD       = MEM_REQ;
        addrD      = MEM_ADDR;
        beD        = MEM_BE;
        rwD        = MEM_RW;
        tmD        = MEM_TM;
        lastD      = MEM_LAST;
        beatsLeftD = beatsLeft;
        inhibitD   = inhibit;
        nTaD       = 1'b1;
        nTbiD      = 1'b1;
        nTeaD      = 1'b1;
        if (claim) begin
            reqD       = 1'b1;
            addrD      = A[23:2];
            beD        = beDecode(SIZ, A[1:0]);
            rwD        = RW;
            tmD        = TM;
            beatsLeftD = (lineReq && BURST_EN) ? 2'd3 : 2'd0;
            lastD      = !(lineReq && BURST_EN);
            inhibitD   = lineReq && !BURST_EN;
        end else if (beatAck) begin
            nTaD  = 1'b0;
            nTbiD = !inhibit;
            if (MEM_LAST) begin
                reqD = 1'b0;
            end else begin
                // Wrap stays inside the 16-byte line: only A[3:2] advance.
                addrD      = {MEM_ADDR[21:2], MEM_ADDR[1:0] + 2'd1};
                beatsLeftD = beatsLeft - 2'd1;
                lastD      = (beatsLeft == 2'd1);
            end
        end else if (timeout) begin
            reqD  = 1'b0;
            nTeaD = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEM_REQ   <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_BE    <= '0;
            MEM_RW    <= 1'b1;
            MEM_TM    <= '0;
            MEM_LAST  <= 1'b0;
            beatsLeft <= '0;
            inhibit   <= 1'b0;
            nTA       <= 1'b1;
            nTBI      <= 1'b1;
            nTEA      <= 1'b1;
        end else begin
            MEM_REQ   <= reqD;
            MEM_ADDR  <= addrD;
            MEM_BE    <= beD;
            MEM_RW    <= rwD;
            MEM_TM    <= tmD;
            MEM_LAST  <= lastD;
            beatsLeft <= beatsLeftD;
            inhibit   <= inhibitD;
            nTA       <= nTaD;
            nTBI      <= nTbiD;
            nTEA      <= nTeaD;
        end
    end

endmodule

// File: tb/tb_dram_bus_frontend.sv
// Directed bench for dram_bus_frontend: one burst-enabled and one burst-disabled instance share stimulus.
module tb_dram_bus_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] addrIn = '0;
    logic [1:0]  tt = 2'b00;
    logic [2:0]  tm = 3'b000;
    logic [1:0]  siz = 2'b00;
    logic        rw = 1'b1;
    logic        nTs = 1'b1;
    logic        nMi = 1'b1;
    logic        memAck = 1'b0;

    logic        bTa, bTbi, bTea, bReq, bRw, bLast;
    logic [21:0] bAddr;
    logic [3:0]  bBe;
    logic [2:0]  bTm;
    logic        nbTa, nbTbi, nbTea, nbReq, nbRw, nbLast;
    logic [21:0] nbAddr;
    logic [3:0]  nbBe;
    logic [2:0]  nbTm;

    int nCompared = 0;
    int nMismatched = 0;
    int taCntB = 0, tbiCntB = 0, teaCntB = 0, reqRiseB = 0;
    int taCntN = 0, tbiCntN = 0;
    logic reqPrevB = 1'b0;

    always #5 clk = ~clk;

    dram_bus_frontend #(.TIMEOUT_CYCLES(8), .BURST_EN(1'b1)) dut (
        .CLK(clk), .RESET(rst), .A(addrIn), .TT(tt), .TM(tm), .SIZ(siz), .RW(rw),
        .nTS(nTs), .nMI(nMi), .nTA(bTa), .nTBI(bTbi), .nTEA(bTea), .MEM_REQ(bReq),
        .MEM_ADDR(bAddr), .MEM_BE(bBe), .MEM_RW(bRw), .MEM_TM(bTm), .MEM_LAST(bLast),
        .MEM_ACK(memAck)
    );

    dram_bus_frontend #(.TIMEOUT_CYCLES(8), .BURST_EN(1'b0)) dutNb (
        .CLK(clk), .RESET(rst), .A(addrIn), .TT(tt), .TM(tm), .SIZ(siz), .RW(rw),
        .nTS(nTs), .nMI(nMi), .nTA(nbTa), .nTBI(nbTbi), .nTEA(nbTea), .MEM_REQ(nbReq),
        .MEM_ADDR(nbAddr), .MEM_BE(nbBe), .MEM_RW(nbRw), .MEM_TM(nbTm), .MEM_LAST(nbLast),
        .MEM_ACK(memAck)
    );

    always @(negedge clk) begin
        if (!bTa)  taCntB++;
        if (!bTbi) tbiCntB++;
        if (!bTea) teaCntB++;
        if (bReq && !reqPrevB) reqRiseB++;
        reqPrevB = bReq;
        if (!nbTa)  taCntN++;
        if (!nbTbi) tbiCntN++;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        nTs = 1'b1;
        memAck = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Presents one nTS cycle; returns on the negedge after the sampling edge.
    task automatic startCycle(input logic [23:0] a, input logic [1:0] s, input logic r,
                              input logic [2:0] m, input logic mi, input logic [1:0] t);
        addrIn = a; siz = s; rw = r; tm = m; nMi = mi; tt = t;
        nTs = 1'b0;
        @(negedge clk);
        nTs = 1'b1;
        nMi = 1'b1;
    endtask

    task automatic serveBeat(input bit nb, input int delay, output logic [21:0] addr,
                             output logic [3:0] be, output logic last);
        int waited = 0;
        while (!(nb ? nbReq : bReq) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkVal("reqWait", {31'd0, (nb ? nbReq : bReq)}, 32'd1);
        addr = nb ? nbAddr : bAddr;
        be   = nb ? nbBe : bBe;
        last = nb ? nbLast : bLast;
        repeat (delay) @(negedge clk);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL globalTimeout: got stuck, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [21:0] addr;
        logic [3:0]  be;
        logic        last;
        int taBase, tbiBase, teaBase, riseBase;
        logic [21:0] lineAddrs [4];
        lineAddrs[0] = 22'h7; lineAddrs[1] = 22'h4; lineAddrs[2] = 22'h5; lineAddrs[3] = 22'h6;

        doReset();
        checkVal("rstCtl", {26'd0, bTa, bTbi, bTea, bReq, bRw, bLast}, 32'b111010);
        checkVal("rstData", {3'd0, bAddr, bBe, bTm}, 32'd0);

        // Long read at 0x000104
        taBase = taCntB; riseBase = reqRiseB;
        startCycle(24'h000104, 2'b00, 1'b1, 3'b010, 1'b1, 2'b00);
        checkVal("longTm", bTm, 3'b010);
        checkVal("longRw", bRw, 1);
        serveBeat(0, 3, addr, be, last);
        checkVal("longAddr", addr, 22'h000041);
        checkVal("longBe", be, 4'b1111);
        checkVal("longLast", last, 1);
        checkVal("longTaReq", {30'd0, bTa, bReq}, 32'b00);
        repeat (3) @(negedge clk);
        checkVal("longTaCnt", taCntB - taBase, 1);
        checkVal("longReqCnt", reqRiseB - riseBase, 1);

        // Byte write at A[1:0]=10
        doReset();
        taBase = taCntB;
        startCycle(24'h000102, 2'b01, 1'b0, 3'b101, 1'b1, 2'b00);
        checkVal("byteBe", bBe, 4'b0010);
        checkVal("byteRw", bRw, 0);
        checkVal("byteTm", bTm, 3'b101);
        serveBeat(0, 1, addr, be, last);
        checkVal("byteAddr", addr, 22'h000040);
        checkVal("byteTa", bTa, 0);
        repeat (3) @(negedge clk);
        checkVal("byteTaCnt", taCntB - taBase, 1);

        // Line read at 0x00001C, burst enabled, then back-to-back nTS in the final nTA cycle
        doReset();
        taBase = taCntB; tbiBase = tbiCntB; riseBase = reqRiseB;
        startCycle(24'h00001C, 2'b11, 1'b1, 3'b000, 1'b1, 2'b01);
        for (int k = 0; k < 4; k++) begin
            serveBeat(0, k, addr, be, last);
            checkVal($sformatf("lineAddr%0d", k), addr, lineAddrs[k]);
            checkVal($sformatf("lineLast%0d", k), last, (k == 3) ? 1 : 0);
            checkVal($sformatf("lineTa%0d", k), {30'd0, bTa, bTbi}, 32'b01);
        end
        startCycle(24'h000200, 2'b00, 1'b1, 3'b000, 1'b1, 2'b00);
        checkVal("b2bReq", bReq, 1);
        checkVal("b2bAddr", bAddr, 22'h000080);
        serveBeat(0, 0, addr, be, last);
        repeat (3) @(negedge clk);
        checkVal("lineTaCnt", taCntB - taBase, 5);
        checkVal("lineTbiCnt", tbiCntB - tbiBase, 0);
        checkVal("lineReqRise", reqRiseB - riseBase, 2);

        // Same line with bursts disabled
        doReset();
        taBase = taCntN; tbiBase = tbiCntN;
        startCycle(24'h00001C, 2'b11, 1'b1, 3'b000, 1'b1, 2'b00);
        serveBeat(1, 2, addr, be, last);
        checkVal("nbAddr", addr, 22'h7);
        checkVal("nbLast", last, 1);
        checkVal("nbTaTbiReq", {29'd0, nbTa, nbTbi, nbReq}, 32'b000);
        repeat (3) @(negedge clk);
        checkVal("nbTaCnt", taCntN - taBase, 1);
        checkVal("nbTbiCnt", tbiCntN - tbiBase, 1);

        // Unclaimed cycles and a stray ACK
        doReset();
        taBase = taCntB; riseBase = reqRiseB;
        startCycle(24'hC00000, 2'b00, 1'b1, 3'b000, 1'b1, 2'b00);
        repeat (3) @(negedge clk);
        startCycle(24'h000100, 2'b00, 1'b1, 3'b000, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        startCycle(24'h000100, 2'b00, 1'b1, 3'b000, 1'b1, 2'b10);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("missReqRise", reqRiseB - riseBase, 0);
        checkVal("missTaCnt", taCntB - taBase, 0);

        // Timeout with no ACK
        doReset();
        teaBase = teaCntB; taBase = taCntB;
        startCycle(24'h000300, 2'b00, 1'b1, 3'b000, 1'b1, 2'b00);
        repeat (7) @(negedge clk);
        checkVal("toBefore", {30'd0, bReq, bTea}, 32'b11);
        @(negedge clk);
        checkVal("toFire", {30'd0, bReq, bTea}, 32'b00);
        @(negedge clk);
        checkVal("toPulse", bTea, 1);
        repeat (2) @(negedge clk);
        checkVal("toTeaCnt", teaCntB - teaBase, 1);
        checkVal("toTaCnt", taCntB - taBase, 0);

        // ACK on the limit cycle wins
        doReset();
        teaBase = teaCntB; taBase = taCntB;
        startCycle(24'h000300, 2'b00, 1'b1, 3'b000, 1'b1, 2'b00);
        repeat (7) @(negedge clk);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        checkVal("limAck", {29'd0, bTa, bTea, bReq}, 32'b010);
        repeat (3) @(negedge clk);
        checkVal("limTeaCnt", teaCntB - teaBase, 0);
        checkVal("limTaCnt", taCntB - taBase, 1);

        // Reset during beat 2 of a line
        doReset();
        startCycle(24'h00001C, 2'b11, 1'b1, 3'b011, 1'b1, 2'b00);
        serveBeat(0, 1, addr, be, last);
        checkVal("midBeat2", {9'd0, bReq, bAddr}, {9'd0, 1'b1, 22'h4});
        rst = 1'b1;
        @(negedge clk);
        checkVal("midRstCtl", {26'd0, bTa, bTbi, bTea, bReq, bRw, bLast}, 32'b111010);
        checkVal("midRstData", {3'd0, bAddr, bBe, bTm}, 32'd0);
        rst = 1'b0;
        taBase = taCntB; teaBase = teaCntB;
        repeat (12) @(negedge clk);
        checkVal("midAfter", {taCntB - taBase, teaCntB - teaBase, {31'd0, bReq}}, 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
